via_shift_xcvr: RTL

Parametrised VIA shift-register transceiver that drives CB1/CB2 for both the Mac Plus keyboard protocol and the Mac SE ADB transceiver link. It generates the shift clock and moves bytes between the VIA and the keyboard/ADB models. It also adds a receive FIFO so device bytes are no longer lost while the Mac is busy. It sits between the via6522 instance and ps2_kbd/adb inside the data controller.

---
 rtl/via_shift_pkg.sv | 23 ++
 rtl/via_shift_fifo.sv | 76 +++++++
 rtl/via_shift_xcvr.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/via_shift_pkg.sv
// ---------------------------------------------------------------------------
// via_shift_pkg
// Shared types and constants for the VIA shift-register transceiver.
//   state_t          : transceiver state (IDLE, TX, WAIT_RX, RX)
//   MODE_PLUS/ADB    : values of the mode input
//   DIV_*_DEFAULT    : default shift-clock half-period terminal counts
// ---------------------------------------------------------------------------
package via_shift_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TX      = 2'd1,
    WAIT_RX = 2'd2,
    RX      = 2'd3
  } state_t;

  localparam logic MODE_PLUS = 1'b0;
  localparam logic MODE_ADB  = 1'b1;

  localparam int DIV_PLUS_DEFAULT = 1300;
  localparam int DIV_ADB_DEFAULT  = 168;

endpackage

// File: rtl/via_shift_fifo.sv
// ---------------------------------------------------------------------------
// via_shift_fifo
// Small synchronous FIFO holding device-to-Mac bytes until the VIA is ready.
// Ports:
//   clk32, _systemReset : clock, asynchronous active-low reset
//   i_en                : clock enable, nothing changes without it
//   i_clr               : synchronous clear (empties the FIFO)
//   i_push, i_data      : write request and byte
//   i_pop               : read request (head advances)
//   o_data              : current head byte
//   o_full, o_empty     : occupancy flags
//   o_level             : number of stored bytes
// A push while full is accepted only if a pop happens in the same tick.
// ---------------------------------------------------------------------------
module via_shift_fifo #(
  parameter  int DATA_W   = 8,
  parameter  int RX_DEPTH = 4,
  localparam int PTR_W    = $clog2(RX_DEPTH),
  localparam int LVL_W    = PTR_W + 1
) (
  input  logic              clk32,
  input  logic              _systemReset,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [LVL_W-1:0]  o_level
);

  logic [DATA_W-1:0] r_mem [RX_DEPTH];
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [LVL_W-1:0]  r_level;
  logic              w_doPop;
  logic              w_doPush;

  assign o_full   = (r_level == LVL_W'(RX_DEPTH));
  assign o_empty  = (r_level == '0);
  assign o_level  = r_level;
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  // Pointers and occupancy; pointers wrap naturally since depth is 2^n
  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_level <= '0;
    end else if (i_en) begin
      if (i_clr) begin
        r_rdPtr <= '0;
        r_wrPtr <= '0;
        r_level <= '0;
      end else begin
        if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
        if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
        case ({w_doPush, w_doPop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase
      end
    end
  end

  // Storage needs no reset; the level gates what is valid
  always_ff @(posedge clk32) begin
    if (i_en && !i_clr && w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/via_shift_xcvr.sv
// ---------------------------------------------------------------------------
// via_shift_xcvr
// VIA shift-register transceiver for the Mac Plus keyboard and Mac SE ADB
// links: generates CB1 (shift_clk), samples Mac bytes from CB2, presents
// device bytes on CB2 input, and buffers device bytes for the Mac.
// Configuration macro: VIA_SHIFT_RXFIFO_EN
//   defined   -> RX_DEPTH-entry receive FIFO (via_shift_fifo)
//   undefined -> single holding register, new byte overwrites unread one
// Ports:
//   clk32, _systemReset : clock, asynchronous active-low reset
//   clk8_en_p           : 8 MHz tick, all state advances only on it
//   clr                 : synchronous clear, same effect as reset
//   mode                : 0 Plus keyboard, 1 ADB
//   kbddat_i            : resolved CB2 line from the VIA
//   adb_listen          : ADB controller ready for a command byte
//   rx_data, rx_strobe  : byte from device, push strobe
//   shift_clk           : to VIA CB1
//   shift_data          : to VIA CB2 input
//   tx_data, tx_strobe  : byte from Mac, one-tick valid pulse
//   busy                : shifting (TX or RX)
//   rx_overflow         : sticky, a device byte was lost
//   rx_level            : receive buffer occupancy
// ---------------------------------------------------------------------------
module via_shift_xcvr
  import via_shift_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 11,
  parameter int DIV_PLUS = DIV_PLUS_DEFAULT,
  parameter int DIV_ADB  = DIV_ADB_DEFAULT,
  parameter int RX_DEPTH = 4
) (
  input  logic                      clk32,
  input  logic                      _systemReset,
  input  logic                      clk8_en_p,
  input  logic                      clr,
  input  logic                      mode,
  input  logic                      kbddat_i,
  input  logic                      adb_listen,
  input  logic [DATA_W-1:0]         rx_data,
  input  logic                      rx_strobe,
  output logic                      shift_clk,
  output logic                      shift_data,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_strobe,
  output logic                      busy,
  output logic                      rx_overflow,
  output logic [$clog2(RX_DEPTH):0] rx_level
);

  localparam int LVL_W = $clog2(RX_DEPTH) + 1;
  localparam int BIT_W = $clog2(DATA_W);

  state_t            r_state;
  state_t            w_next;
  logic              r_mode;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_shiftClk;
  logic              r_shiftData;
  logic [BIT_W-1:0]  r_bitCnt;
  logic [DATA_W-1:0] r_txSr;
  logic [DATA_W-1:0] r_rxSr;
  logic [DATA_W-1:0] r_txData;
  logic              r_txStrobe;
  logic              r_busy;
  logic              r_overflow;
  logic              r_atn;
  logic              r_atnFresh;

  logic              w_active;
  logic              w_term;
  logic              w_fall;
  logic              w_rise;
  logic              w_byteEnd;
  logic              w_pop;
  logic              w_atn;
  logic              w_busyNext;
  logic              w_txStrobeNext;
  logic              w_empty;
  logic              w_pushDropped;
  logic [DATA_W-1:0] w_head;
  logic [LVL_W-1:0]  w_level;

  // Divider runs only while shifting; mode is frozen outside IDLE
  assign w_active  = (r_state == TX) || (r_state == RX);
  assign w_term    = w_active &&
                     (r_cnt == ((r_mode == MODE_ADB) ? CNT_W'(DIV_ADB) : CNT_W'(DIV_PLUS)));
  assign w_fall    = w_term && r_shiftClk;
  assign w_rise    = w_term && !r_shiftClk;
  assign w_byteEnd = w_rise && (r_bitCnt == BIT_W'(DATA_W - 1));

  // Right after reset/clr the attention flag reflects the mode at release
  assign w_atn = r_atnFresh ? (mode == MODE_ADB) : r_atn;

`ifdef VIA_SHIFT_RXFIFO_EN
  logic w_full;

  via_shift_fifo #(
    .DATA_W   (DATA_W),
    .RX_DEPTH (RX_DEPTH)
  ) u_fifo (
    .clk32        (clk32),
    ._systemReset (_systemReset),
    .i_en         (clk8_en_p),
    .i_clr        (clr),
    .i_push       (rx_strobe),
    .i_pop        (w_pop),
    .i_data       (rx_data),
    .o_data       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_level      (w_level)
  );

  assign w_pushDropped = rx_strobe && w_full && !w_pop;
`else
  logic [DATA_W-1:0] r_hold;
  logic              r_holdValid;

  // Single holding register; a new byte always wins over an unread one
  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      r_hold      <= '0;
      r_holdValid <= 1'b0;
    end else if (clk8_en_p) begin
      if (clr) begin
        r_holdValid <= 1'b0;
      end else if (rx_strobe) begin
        r_hold      <= rx_data;
        r_holdValid <= 1'b1;
      end else if (w_pop) begin
        r_holdValid <= 1'b0;
      end
    end
  end

  assign w_head        = r_hold;
  assign w_empty       = !r_holdValid;
  assign w_level       = {{(LVL_W-1){1'b0}}, r_holdValid};
  assign w_pushDropped = rx_strobe && r_holdValid && !w_pop;
`endif

  // State register
  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset)  r_state <= IDLE;
    else if (clk8_en_p) r_state <= clr ? IDLE : w_next;
  end

  // Next state; the buffer head is popped on entry to RX
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (mode == MODE_PLUS) begin
          if (!kbddat_i) w_next = TX;
        end else if (w_atn && adb_listen) begin
          w_next = TX;
        end else if (!w_empty) begin
          w_next = RX;
          w_pop  = 1'b1;
        end
      end
      TX:      if (w_byteEnd) w_next = (r_mode == MODE_ADB) ? IDLE : WAIT_RX;
      WAIT_RX: if (kbddat_i && !w_empty) begin
                 w_next = RX;
                 w_pop  = 1'b1;
               end
      RX:      if (w_byteEnd) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode for the registered busy and strobe
  always_comb begin
    w_busyNext     = (w_next == TX) || (w_next == RX);
    w_txStrobeNext = (r_state == TX) && w_byteEnd;
  end

  // Datapath: divider, shift registers, flags
  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      r_mode      <= MODE_PLUS;
      r_cnt       <= '0;
      r_shiftClk  <= 1'b1;
      r_shiftData <= 1'b1;
      r_bitCnt    <= '0;
      r_txSr      <= '0;
      r_rxSr      <= '0;
      r_txData    <= '0;
      r_txStrobe  <= 1'b0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
      r_atn       <= 1'b0;
      r_atnFresh  <= 1'b1;
    end else if (clk8_en_p) begin
      if (clr) begin
        r_mode      <= MODE_PLUS;
        r_cnt       <= '0;
        r_shiftClk  <= 1'b1;
        r_shiftData <= 1'b1;
        r_bitCnt    <= '0;
        r_txSr      <= '0;
        r_rxSr      <= '0;
        r_txData    <= '0;
        r_txStrobe  <= 1'b0;
        r_busy      <= 1'b0;
        r_overflow  <= 1'b0;
        r_atn       <= 1'b0;
        r_atnFresh  <= 1'b1;
      end else begin
        r_atnFresh <= 1'b0;
        if (r_state == IDLE) r_mode <= mode;

        if (r_state == IDLE && mode == MODE_ADB) begin
          if (w_next == TX)  r_atn <= 1'b0;
          else if (kbddat_i) r_atn <= 1'b1;
          else               r_atn <= w_atn;
        end else begin
          r_atn <= w_atn;
        end

        if (!w_active) begin
          r_cnt      <= '0;
          r_shiftClk <= 1'b1;
          r_bitCnt   <= '0;
        end else if (w_term) begin
          r_cnt      <= '0;
          r_shiftClk <= !r_shiftClk;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end

        if (w_fall && r_state == TX) r_txSr <= {r_txSr[DATA_W-2:0], kbddat_i};
        if (w_fall && r_state == RX) r_shiftData <= r_rxSr[BIT_W'(DATA_W - 1) - r_bitCnt];
        if (w_rise) r_bitCnt <= w_byteEnd ? '0 : r_bitCnt + 1'b1;

        if (w_pop) r_rxSr <= w_head;

        r_txStrobe <= w_txStrobeNext;
        if (w_txStrobeNext) r_txData <= r_txSr;
        r_busy <= w_busyNext;
        if (w_pushDropped) r_overflow <= 1'b1;
      end
    end
  end

  assign shift_clk   = r_shiftClk;
  assign shift_data  = r_shiftData;
  assign tx_data     = r_txData;
  assign tx_strobe   = r_txStrobe;
  assign busy        = r_busy;
  assign rx_overflow = r_overflow;
  assign rx_level    = w_level;

endmodule
